// File: rtl/conv_1x1_pkg.sv
// Shared types and width helpers for the 1x1 convolution controller.
// Optional cycle counter is enabled with CONV_1X1_CTRL_PERF_EN (see conv_1x1_ctrl).
package conv_1x1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IMAGE_WIDTH     = 64;
    localparam int DEF_IMAGE_HEIGHT    = 64;
    localparam int DEF_CHANNEL_NUM_IN  = 256;
    localparam int DEF_CHANNEL_NUM_OUT = 7;

    localparam int DEF_IMAGE_SIZE = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;
    localparam int DEF_E          = DEF_CHANNEL_NUM_IN * DEF_IMAGE_SIZE;
    localparam int DEF_PX_W       = cnt_w(DEF_IMAGE_SIZE);
    localparam int DEF_IN_W       = cnt_w(DEF_CHANNEL_NUM_IN);
    localparam int DEF_OUT_W      = cnt_w(DEF_CHANNEL_NUM_OUT);
    localparam int DEF_R_W        = cnt_w(DEF_E + 1);

endpackage

// File: rtl/conv_1x1_wrap_cnt.sv
// Wrapping counter 0..MAX-1 with enable, synchronous clear and terminal-count flag.
module conv_1x1_wrap_cnt
    import conv_1x1_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = cnt_w(MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc  = (cnt_q == W'(MAX - 1));
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_1x1_ctrl.sv
// Sequencer for a 1x1 convolution layer: loads weights, streams pixels, counts results.
// Define CONV_1X1_CTRL_PERF_EN to add the perf_cycles busy-cycle counter output.
module conv_1x1_ctrl
    import conv_1x1_pkg::*;
#(
    parameter int IMAGE_WIDTH     = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT    = DEF_IMAGE_HEIGHT,
    parameter int CHANNEL_NUM_IN  = DEF_CHANNEL_NUM_IN,
    parameter int CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               weight_valid_in,
    output logic                               weight_ready,
    input  logic                               pxl_valid_in,
    output logic                               pxl_ready,
    input  logic                               mul_valid_in,
    output logic                               load_weights,
    output logic [cnt_w(CHANNEL_NUM_IN)-1:0]   in_ch,
    output logic [cnt_w(CHANNEL_NUM_OUT)-1:0]  out_ch,
`ifdef CONV_1X1_CTRL_PERF_EN
    output logic [31:0]                        perf_cycles,
`endif
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int E          = CHANNEL_NUM_IN * IMAGE_SIZE;
    localparam int PX_W       = cnt_w(IMAGE_SIZE);
    localparam int IN_W       = cnt_w(CHANNEL_NUM_IN);
    localparam int OUT_W      = cnt_w(CHANNEL_NUM_OUT);
    localparam int R_W        = cnt_w(E + 1);

    state_e         state_q, state_d;
    logic           load_weights_q, load_weights_d;
    logic           weight_ready_q, weight_ready_d;
    logic           pxl_ready_q, pxl_ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [R_W-1:0] r_cnt_q, r_cnt_d;

    logic            start_acc, w_acc, px_acc, r_full, drain_hit, next_ch;
    logic            w_tc, px_tc, in_tc, out_tc;
    logic [IN_W-1:0] w_cnt;
    logic [PX_W-1:0] px_cnt;
    logic            unused_cnt_bits;

    assign start_acc = (state_q == IDLE) && start;
    assign w_acc     = (state_q == LOAD_W) && weight_valid_in && weight_ready_q;
    assign px_acc    = (state_q == STREAM) && pxl_valid_in && pxl_ready_q;
    assign r_full    = (r_cnt_q == R_W'(E));
    assign drain_hit = (state_q == DRAIN) && r_full;
    assign next_ch   = drain_hit && !out_tc;

    // Only the terminal flags of the weight and pixel counters steer the FSM.
    assign unused_cnt_bits = ^{w_cnt, px_cnt};

    conv_1x1_wrap_cnt #(.MAX(CHANNEL_NUM_IN), .W(IN_W)) u_w_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_acc),
        .clr   (start_acc || next_ch),
        .cnt   (w_cnt),
        .tc    (w_tc)
    );

    conv_1x1_wrap_cnt #(.MAX(IMAGE_SIZE), .W(PX_W)) u_px_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (px_acc),
        .clr   (start_acc || next_ch),
        .cnt   (px_cnt),
        .tc    (px_tc)
    );

    conv_1x1_wrap_cnt #(.MAX(CHANNEL_NUM_IN), .W(IN_W)) u_in_ch (
        .clk   (clk),
        .reset (reset),
        .en    (px_acc && px_tc),
        .clr   (start_acc || next_ch),
        .cnt   (in_ch),
        .tc    (in_tc)
    );

    conv_1x1_wrap_cnt #(.MAX(CHANNEL_NUM_OUT), .W(OUT_W)) u_out_ch (
        .clk   (clk),
        .reset (reset),
        .en    (next_ch),
        .clr   (start_acc),
        .cnt   (out_ch),
        .tc    (out_tc)
    );

    always_comb begin
        state_d        = state_q;
        load_weights_d = 1'b0;
        done_d         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d        = LOAD_W;
                    load_weights_d = 1'b1;
                end
            end
            LOAD_W: begin
                if (w_acc && w_tc) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (px_acc && px_tc && in_tc) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (r_full) begin
                    if (!out_tc) begin
                        state_d        = LOAD_W;
                        load_weights_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        weight_ready_d = (state_d == LOAD_W);
        pxl_ready_d    = (state_d == STREAM);
        busy_d         = (state_d != IDLE);
    end

    // Result strobes outside STREAM/DRAIN or past the expected total are overruns.
    always_comb begin
        r_cnt_d = r_cnt_q;
        err_d   = err_q;
        if (start_acc || drain_hit) begin
            r_cnt_d = '0;
        end else if (mul_valid_in && (state_q == STREAM || state_q == DRAIN) && !r_full) begin
            r_cnt_d = r_cnt_q + 1'b1;
        end
        if (start_acc) begin
            err_d = 1'b0;
        end
        if (mul_valid_in && (state_q == IDLE || state_q == LOAD_W || r_full)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            load_weights_q <= 1'b0;
            weight_ready_q <= 1'b0;
            pxl_ready_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            r_cnt_q        <= '0;
        end else begin
            state_q        <= state_d;
            load_weights_q <= load_weights_d;
            weight_ready_q <= weight_ready_d;
            pxl_ready_q    <= pxl_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            r_cnt_q        <= r_cnt_d;
        end
    end

    assign load_weights = load_weights_q;
    assign weight_ready = weight_ready_q;
    assign pxl_ready    = pxl_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

`ifdef CONV_1X1_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        if (start_acc) begin
            perf_cycles_d = '0;
        end else if (busy_q && (perf_cycles_q != '1)) begin
            perf_cycles_d = perf_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
`endif

endmodule

// File: tb/tb_conv_1x1_ctrl.sv
// Directed self-checking bench for conv_1x1_ctrl on a 2x2 image, 3 input and 2 output channels.
module tb_conv_1x1_ctrl;

    localparam int IW   = 2;
    localparam int IH   = 2;
    localparam int CIN  = 3;
    localparam int COUT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       weight_valid_in = 1'b0;
    logic       pxl_valid_in = 1'b0;
    logic       mul_valid_in = 1'b0;
    logic       weight_ready, pxl_ready, load_weights, busy, done, err;
    logic [1:0] in_ch;
    logic [0:0] out_ch;
`ifdef CONV_1X1_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    int lwPulses    = 0;
    int donePulses  = 0;
    int busyCycles  = 0;
    int doneMark    = 0;

    always #5 clk = ~clk;

    conv_1x1_ctrl #(
        .IMAGE_WIDTH     (IW),
        .IMAGE_HEIGHT    (IH),
        .CHANNEL_NUM_IN  (CIN),
        .CHANNEL_NUM_OUT (COUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .weight_valid_in (weight_valid_in),
        .weight_ready    (weight_ready),
        .pxl_valid_in    (pxl_valid_in),
        .pxl_ready       (pxl_ready),
        .mul_valid_in    (mul_valid_in),
        .load_weights    (load_weights),
        .in_ch           (in_ch),
        .out_ch          (out_ch),
`ifdef CONV_1X1_CTRL_PERF_EN
        .perf_cycles     (perf_cycles),
`endif
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    task automatic checkOutput(input string tag, input int obs, input int exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs from a falling edge and land on the next falling edge.
    task automatic applyStimulus(input logic st, input logic wv, input logic pv, input logic mv);
        start           = st;
        weight_valid_in = wv;
        pxl_valid_in    = pv;
        mul_valid_in    = mv;
        @(negedge clk);
        if (load_weights) lwPulses++;
        if (done) donePulses++;
        if (busy) busyCycles++;
    endtask

    task automatic loadWeights();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("lw_pulse_width", int'(load_weights), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("w_ready_after_2", int'(weight_ready), 1);
        checkOutput("px_ready_after_2w", int'(pxl_ready), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("px_ready_after_3w", int'(pxl_ready), 1);
        checkOutput("w_ready_after_3w", int'(weight_ready), 0);
    endtask

    task automatic streamPixels(input logic wv, input logic mv);
        for (int i = 0; i < IW * IH * CIN; i++) begin
            applyStimulus(1'b0, wv, 1'b1, mv);
            if (i == 3) checkOutput("in_ch_after_4px", int'(in_ch), 1);
            if (i == 7) checkOutput("in_ch_after_8px", int'(in_ch), 2);
        end
        checkOutput("px_ready_in_drain", int'(pxl_ready), 0);
        checkOutput("busy_in_drain", int'(busy), 1);
    endtask

    task automatic mulStrobes(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_weight_ready", int'(weight_ready), 0);
        checkOutput("rst_pxl_ready", int'(pxl_ready), 0);
        checkOutput("rst_load_weights", int'(load_weights), 0);
        checkOutput("rst_done_err", int'({done, err}), 0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("idle_ignores_valids", int'({weight_ready, pxl_ready, busy}), 0);

        // Nominal pass, with weight_valid_in held high while streaming channel 0
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_load_weights", int'(load_weights), 1);
        checkOutput("start_busy", int'(busy), 1);
        checkOutput("start_weight_ready", int'(weight_ready), 1);
        checkOutput("start_out_ch", int'(out_ch), 0);
        loadWeights();
        streamPixels(1'b1, 1'b0);
        mulStrobes(12);
        checkOutput("ch0_still_drain", int'(load_weights), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ch1_load_weights", int'(load_weights), 1);
        checkOutput("ch1_out_ch", int'(out_ch), 1);
        loadWeights();
        streamPixels(1'b0, 1'b1);
        checkOutput("ch1_no_done_yet", int'(done), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("nominal_done", int'(done), 1);
        checkOutput("nominal_idle_busy", int'(busy), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("done_one_cycle", int'(done), 0);
        checkOutput("nominal_lw_pulses", lwPulses, 2);
        checkOutput("nominal_done_pulses", donePulses, 1);
        checkOutput("nominal_err", int'(err), 0);

        // Overrun: thirteenth result strobe on out_ch 0
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("restart_out_ch", int'(out_ch), 0);
        loadWeights();
        streamPixels(1'b0, 1'b0);
        mulStrobes(12);
        checkOutput("ovr_err_before", int'(err), 0);
        mulStrobes(1);
        checkOutput("ovr_err_set", int'(err), 1);
        loadWeights();
        streamPixels(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovr_done", int'(done), 1);
        checkOutput("ovr_err_sticky", int'(err), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("ovr_err_cleared", int'(err), 0);

        // Reset in the middle of streaming after 5 pixels
        loadWeights();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("mid_in_ch", int'(in_ch), 1);
        doneMark = donePulses;
        #2 reset = 1'b0;
        #1;
        checkOutput("async_rst_busy", int'(busy), 0);
        checkOutput("async_rst_pxl_ready", int'(pxl_ready), 0);
        checkOutput("async_rst_in_ch", int'(in_ch), 0);
        checkOutput("async_rst_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("after_rst_no_done", donePulses - doneMark, 0);

        // Full pass after reset, with start pulsed while in DRAIN
        busyCycles = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_out_ch", int'(out_ch), 0);
        loadWeights();
        streamPixels(1'b0, 1'b0);
        mulStrobes(12);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        loadWeights();
        streamPixels(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("busy_start_no_lw", int'(load_weights), 0);
        checkOutput("busy_start_out_ch", int'(out_ch), 1);
        mulStrobes(12);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pass4_done", int'(done), 1);
        checkOutput("pass4_busy_cycles", busyCycles, 59);
`ifdef CONV_1X1_CTRL_PERF_EN
        checkOutput("perf_cycles", int'(perf_cycles), 59);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pass4_done_count", donePulses - doneMark, 1);
        checkOutput("pass4_idle", int'(busy), 0);

        // Result strobe while idle is an overrun, cleared by the next start
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("idle_strobe_err", int'(err), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_strobe_err_clr", int'(err), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/conv_1x1_ctrl.md
CONV_1X1_CTRL -- requirements
Module: conv_1x1_ctrl

Interface
REQ-001 Parameter IMAGE_WIDTH, default 64, pixels per row.
REQ-002 Parameter IMAGE_HEIGHT, default 64, rows per frame; IMAGE_SIZE = IMAGE_WIDTH*IMAGE_HEIGHT.
REQ-003 Parameter CHANNEL_NUM_IN, default 256, input channels (weights per output channel).
REQ-004 Parameter CHANNEL_NUM_OUT, default 7, output channels.
REQ-005 Port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 Port reset, input, 1, asynchronous active-low reset.
REQ-007 Port start, input, 1, begin a full layer pass (sampled in IDLE only).
REQ-008 Port weight_valid_in / weight_ready, input / output, 1 each, weight-stream handshake.
REQ-009 Port pxl_valid_in / pxl_ready, input / output, 1 each, pixel-stream handshake (channel-major order).
REQ-010 Port mul_valid_in, input, 1, result strobe from the fp_mul core.
REQ-011 Port load_weights, output, 1, one-cycle pulse clearing the weight-buffer pointer.
REQ-012 Port in_ch, output, clog2(CHANNEL_NUM_IN), current input-channel index selecting the active weight.
REQ-013 Port out_ch, output, clog2(CHANNEL_NUM_OUT), current output-channel index.
REQ-014 Ports busy, done, err, outputs, 1 each: pass active, one-cycle completion pulse, sticky result-overrun flag.

Function
REQ-015 FSM states IDLE, LOAD_W, STREAM, DRAIN; state register, counters and outputs registered.
REQ-016 IDLE: start=1 -> LOAD_W, out_ch=0, load_weights pulses in the cycle LOAD_W is entered.
REQ-017 LOAD_W: weight_ready=1; each weight_valid_in&weight_ready increments w_cnt; the CHANNEL_NUM_IN-th accept -> STREAM, w_cnt=0.
REQ-018 STREAM: pxl_ready=1; each accept increments px_cnt; px_cnt wraps at IMAGE_SIZE-1 and increments in_ch.
REQ-019 STREAM: accept with in_ch=CHANNEL_NUM_IN-1 and px_cnt=IMAGE_SIZE-1 -> DRAIN.
REQ-020 Result counter r_cnt increments on every mul_valid_in in STREAM or DRAIN; expected total per output channel E = CHANNEL_NUM_IN*IMAGE_SIZE.
REQ-021 DRAIN: r_cnt reaching E -> if out_ch<CHANNEL_NUM_OUT-1, out_ch+1, r_cnt/in_ch/px_cnt cleared, -> LOAD_W with load_weights pulse; else -> IDLE with done=1 for one cycle.
REQ-022 weight_ready=0 outside LOAD_W; pxl_ready=0 outside STREAM; valid without ready is ignored, never counted.
REQ-023 mul_valid_in in IDLE or LOAD_W, or any strobe beyond E, sets err; err clears only on reset or next accepted start.
REQ-024 busy=1 in every state except IDLE; start while busy is ignored.
REQ-025 Latency: STREAM entered the cycle after the last weight accept; done asserted the cycle after r_cnt reaches E on the final channel.

Reset
REQ-026 reset=0 asynchronously forces IDLE; all counters, in_ch, out_ch, load_weights, weight_ready, pxl_ready, busy, done, err = 0.
REQ-027 Reset mid-pass abandons the pass; no done pulse; next start restarts from out_ch=0.

Configuration
REQ-028 Macro CONV_1X1_CTRL_PERF_EN defined: extra output perf_cycles (32 bits) counts busy cycles, cleared on accepted start, saturating at all-ones.
REQ-029 Macro undefined: perf_cycles port and its counter absent; all other behaviour identical.

Structure
REQ-030 Shared package conv_1x1_pkg holds the FSM state enum and width constants (clog2 of IMAGE_SIZE, CHANNEL_NUM_IN, CHANNEL_NUM_OUT, E).
REQ-031 One sub-module conv_1x1_wrap_cnt (parameterised wrapping counter with enable, clear, terminal-count flag) instantiated for px_cnt, in_ch, w_cnt, out_ch.

Verification (IMAGE_WIDTH=2, IMAGE_HEIGHT=2, CHANNEL_NUM_IN=3, CHANNEL_NUM_OUT=2)
REQ-032 Nominal: start, 3 weights, 12 pixels, 12 mul strobes, twice -> 2 load_weights pulses, done once, err=0.
REQ-033 Back-pressure: weight_valid_in held high during STREAM -> no weight counted; next LOAD_W still needs exactly 3 accepts.
REQ-034 Overrun: 13th mul_valid_in on out_ch=0 -> err=1 and stays 1 until reset or next start.
REQ-035 Reset mid-STREAM after 5 pixels -> all outputs 0 same cycle, no done; new start completes normally.
REQ-036 Start while busy pulsed in DRAIN -> ignored; exactly one done for the pass; with CONV_1X1_CTRL_PERF_EN, perf_cycles equals busy-cycle count.
